// File: rtl/param_chain_loader_if.sv
// Host-side word bus of the parameter chain loader.
//   word_in/word_valid/word_ready : parameter words into the loader (valid/ready)
//   rd_word/rd_valid              : readback words from the chain end (no backpressure)
// master = host, slave = loader.
interface param_chain_loader_if #(
  parameter int WORD_BITS = 8
);
  logic [WORD_BITS-1:0] word_in;
  logic                 word_valid;
  logic                 word_ready;
  logic [WORD_BITS-1:0] rd_word;
  logic                 rd_valid;

  modport master (
    output word_in, word_valid,
    input  word_ready, rd_word, rd_valid
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, rd_word, rd_valid
  );
endinterface

// File: rtl/param_chain_loader.sv
// Serial parameter chain loader.
// Takes host words over a valid/ready handshake and shifts them MSB-first into
// the neuron parameter chain, one bit per clock, raising setup only when a bit
// is actually presented. Bits leaving the chain end are captured into readback
// words so the host sees the previous chain contents during every load.
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : begin a load (sampled in IDLE only)
//   host        : word handshake in, readback words out
//   setup       : chain shift enable (registered, changes with chain_din)
//   chain_din   : serial bit into the first neuron
//   chain_dout  : serial bit from the last neuron
//   busy, done  : load in progress / one-cycle pulse after the final shift
//
// state  | meaning
// IDLE   | waiting for start, chain held
// LOAD   | accepting words and shifting the chain
// FINISH | final shift consumed, done pulse
module param_chain_loader #(
  parameter int CHAIN_BITS = 88,
  parameter int WORD_BITS  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  param_chain_loader_if.slave host,
  output logic                setup,
  output logic                chain_din,
  input  logic                chain_dout,
  output logic                busy,
  output logic                done
);

  localparam int WORDS  = (CHAIN_BITS + WORD_BITS - 1) / WORD_BITS;
  localparam int SHIFTS = WORDS * WORD_BITS;
  localparam int WCW    = $clog2(WORDS + 1);
  localparam int BCW    = $clog2(WORD_BITS + 1);
  localparam int SCW    = $clog2(SHIFTS + 1);

  localparam logic [WCW-1:0] WORDS_L    = WCW'(WORDS);
  localparam logic [SCW-1:0] LAST_SHIFT = SCW'(SHIFTS - 1);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(WORD_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t               state, state_nx;
  logic [WCW-1:0]       word_cnt;
  logic [BCW-1:0]       bits_left;   // bits still waiting in sbuf
  logic [WORD_BITS-1:0] sbuf;
  logic [SCW-1:0]       shift_cnt;   // bits consumed by the chain so far
  logic [WORD_BITS-1:0] cap;
  logic [BCW-1:0]       cap_cnt;
  logic                 hs;
  logic                 last_shift;

  assign hs         = host.word_valid & host.word_ready;
  assign last_shift = setup && (shift_cnt == LAST_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (last_shift) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The first bit of a word is presented on the handshake edge itself, so the
  // buffer only needs to be empty to accept the next word without a gap.
  always_comb begin
    busy            = (state != IDLE);
    done            = (state == FINISH);
    host.word_ready = (state == LOAD) && (word_cnt < WORDS_L) && (bits_left == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      setup         <= 1'b0;
      chain_din     <= 1'b0;
      sbuf          <= '0;
      bits_left     <= '0;
      word_cnt      <= '0;
      shift_cnt     <= '0;
      cap           <= '0;
      cap_cnt       <= '0;
      host.rd_word  <= '0;
      host.rd_valid <= 1'b0;
    end else begin
      host.rd_valid <= 1'b0;

      // The chain shifts on this edge: capture what falls out of its end.
      if (setup) begin
        cap       <= {cap[WORD_BITS-2:0], chain_dout};
        shift_cnt <= shift_cnt + 1'b1;
        if (cap_cnt == LAST_BIT) begin
          host.rd_word  <= {cap[WORD_BITS-2:0], chain_dout};
          host.rd_valid <= 1'b1;
          cap_cnt       <= '0;
        end else begin
          cap_cnt <= cap_cnt + 1'b1;
        end
      end

      case (state)
        LOAD: begin
          if (hs) begin
            setup     <= 1'b1;
            chain_din <= host.word_in[WORD_BITS-1];
            sbuf      <= host.word_in << 1;
            bits_left <= LAST_BIT;
            word_cnt  <= word_cnt + 1'b1;
          end else if (bits_left != '0) begin
            setup     <= 1'b1;
            chain_din <= sbuf[WORD_BITS-1];
            sbuf      <= sbuf << 1;
            bits_left <= bits_left - 1'b1;
          end else begin
            setup     <= 1'b0;
            chain_din <= 1'b0;
          end
        end
        default: begin
          setup     <= 1'b0;
          chain_din <= 1'b0;
          if (state == IDLE && start) begin
            word_cnt  <= '0;
            bits_left <= '0;
            shift_cnt <= '0;
            cap_cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_chain_loader.sv
module tb_param_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start22, start88;
  logic setup22, din22, dout22, busy22, done22;
  logic setup88, din88, dout88, busy88, done88;

  param_chain_loader_if #(.WORD_BITS(8)) h22();
  param_chain_loader_if #(.WORD_BITS(8)) h88();

  param_chain_loader #(.CHAIN_BITS(22), .WORD_BITS(8)) dut22 (
    .clk(clk), .rst_n(rst_n), .start(start22), .host(h22),
    .setup(setup22), .chain_din(din22), .chain_dout(dout22),
    .busy(busy22), .done(done22)
  );

  param_chain_loader #(.CHAIN_BITS(88), .WORD_BITS(8)) dut88 (
    .clk(clk), .rst_n(rst_n), .start(start88), .host(h88),
    .setup(setup88), .chain_din(din88), .chain_dout(dout88),
    .busy(busy88), .done(done88)
  );

  int vectors = 0;
  int errors  = 0;

  // Chain models. The 22-bit chain carries 2 extra bits beyond its end, which
  // supply the don't-care pad bits that lead the readback.
  logic [23:0] ch22, pre22_val;
  logic        pre22 = 1'b0;
  always @(posedge clk)
    if (pre22) ch22 <= pre22_val;
    else if (setup22) ch22 <= {ch22[22:0], din22};
  assign dout22 = ch22[23];

  logic [87:0] ch88, pre88_val;
  logic        pre88 = 1'b0;
  always @(posedge clk)
    if (pre88) ch88 <= pre88_val;
    else if (setup88) ch88 <= {ch88[86:0], din88};
  assign dout88 = ch88[87];

  // Observers, sampled on the falling edge.
  logic clr22 = 1'b0, clr88 = 1'b0;
  int cyc = 0, set_cnt, run, max_run, gap_cnt, hs_cnt, rv_cnt, done_cnt;
  int start_cyc, done_cyc, start_cnt, done_no_rv, done_no_rv88;
  logic busy_q;
  logic [7:0] rd22[$];
  logic [7:0] rd88[$];

  always @(negedge clk) begin
    cyc++;
    if (clr22) begin
      set_cnt = 0; run = 0; max_run = 0; gap_cnt = 0; hs_cnt = 0; rv_cnt = 0;
      done_cnt = 0; start_cyc = 0; done_cyc = 0; start_cnt = 0; done_no_rv = 0;
      busy_q = busy22;
      rd22.delete();
    end else begin
      if (start22 && !busy22) start_cyc = cyc;
      if (busy22 && !busy_q) start_cnt++;
      if (setup22) begin
        set_cnt++; run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (busy22 && !setup22 && !done22) gap_cnt++;
      if (h22.word_valid && h22.word_ready) hs_cnt++;
      if (h22.rd_valid) begin rv_cnt++; rd22.push_back(h22.rd_word); end
      if (done22) begin
        done_cnt++; done_cyc = cyc;
        if (!h22.rd_valid) done_no_rv++;
      end
      busy_q = busy22;
    end
  end

  always @(negedge clk) begin
    if (clr88) begin
      rd88.delete(); done_no_rv88 = 0;
    end else begin
      if (h88.rd_valid) rd88.push_back(h88.rd_word);
      if (done88 && !h88.rd_valid) done_no_rv88++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mon_clear();
    clr22 = 1'b1; clr88 = 1'b1;
    @(negedge clk); #1;
    clr22 = 1'b0; clr88 = 1'b0;
    tick();
  endtask

  task automatic preload22(input logic [23:0] v);
    pre22_val = v; pre22 = 1'b1; tick(); pre22 = 1'b0;
  endtask

  task automatic preload88(input logic [87:0] v);
    pre88_val = v; pre88 = 1'b1; tick(); pre88 = 1'b0;
  endtask

  task automatic do_start(input bit sel);
    if (sel) start88 = 1'b1; else start22 = 1'b1;
    tick();
    start22 = 1'b0; start88 = 1'b0;
  endtask

  task automatic send_word(input bit sel, input logic [7:0] w);
    int n = 0;
    logic ok;
    if (sel) begin h88.word_in = w; h88.word_valid = 1'b1; end
    else     begin h22.word_in = w; h22.word_valid = 1'b1; end
    forever begin
      @(negedge clk);
      ok = sel ? h88.word_ready : h22.word_ready;
      tick();
      n++;
      if (ok) break;
      if (n > 100) begin
        vectors++; errors++;
        $display("FAIL send_timeout: word_ready=0 for %0d cycles, want 1", n);
        break;
      end
    end
    h22.word_valid = 1'b0; h88.word_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget);
    int n = 0;
    while (!(sel ? done88 : done22) && n < budget) begin tick(); n++; end
    vectors++;
    if (!(sel ? done88 : done22)) begin
      errors++;
      $display("FAIL done_timeout: done=0 after %0d cycles, want 1", n);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if ({setup22, din22, h22.word_ready, h22.rd_valid, busy22, done22} !== 6'b0) begin
      errors++;
      $display("FAIL %s_ctrl: setup/din/ready/rd_valid/busy/done=%b want 000000", tag,
               {setup22, din22, h22.word_ready, h22.rd_valid, busy22, done22});
    end
    vectors++;
    if (h22.rd_word !== 8'h00) begin
      errors++;
      $display("FAIL %s_rd_word: got %h want 00", tag, h22.rd_word);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    vectors++;
    if ({setup88, din88, h88.word_ready, h88.rd_valid, busy88, done88, h88.rd_word} !== 14'b0) begin
      errors++;
      $display("FAIL reset_88: outputs=%b want all 0",
               {setup88, din88, h88.word_ready, h88.rd_valid, busy88, done88, h88.rd_word});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    preload22(24'h95A5A5);
    mon_clear();
    do_start(0);
    vectors++;
    if (busy22 !== 1'b1 || h22.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_busy_ready: busy=%b ready=%b want 1 1", busy22, h22.word_ready);
    end
    send_word(0, 8'hFF); send_word(0, 8'hA5); send_word(0, 8'h3C);
    wait_done(0, 40);
    tick();
    vectors++;
    if (set_cnt != 24) begin errors++; $display("FAIL b2b_setup_cycles: got %0d want 24", set_cnt); end
    vectors++;
    if (max_run != 24) begin errors++; $display("FAIL b2b_setup_run: got %0d want 24", max_run); end
    vectors++;
    if (gap_cnt != 1) begin errors++; $display("FAIL b2b_idle_busy_cycles: got %0d want 1", gap_cnt); end
    vectors++;
    if (hs_cnt != 3) begin errors++; $display("FAIL b2b_handshakes: got %0d want 3", hs_cnt); end
    vectors++;
    if (done_cyc - start_cyc != 26) begin
      errors++; $display("FAIL b2b_done_latency: got %0d want 26", done_cyc - start_cyc);
    end
    vectors++;
    if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt); end
    vectors++;
    if (ch22[21:0] !== 22'h3FA53C) begin
      errors++; $display("FAIL b2b_chain: got %h want 3fa53c", ch22[21:0]);
    end
    vectors++;
    if (rv_cnt != 3) begin errors++; $display("FAIL rb_pulses: got %0d want 3", rv_cnt); end
    vectors++;
    if (rd22[0][5:0] !== 6'h15) begin errors++; $display("FAIL rb_word0: got %h want 15 (low 6 bits)", rd22[0][5:0]); end
    vectors++;
    if (rd22[1] !== 8'hA5) begin errors++; $display("FAIL rb_word1: got %h want a5", rd22[1]); end
    vectors++;
    if (rd22[2] !== 8'hA5) begin errors++; $display("FAIL rb_word2: got %h want a5", rd22[2]); end
    vectors++;
    if (done_no_rv != 0) begin errors++; $display("FAIL rb_last_with_done: %0d done cycles without rd_valid, want 0", done_no_rv); end
    vectors++;
    if (busy22 !== 1'b0) begin errors++; $display("FAIL b2b_busy_after: got %b want 0", busy22); end
  endtask

  task automatic test_stall();
    int n = 0;
    logic rdy = 1'b0;
    preload22(24'h000000);
    mon_clear();
    do_start(0);
    send_word(0, 8'hFF); send_word(0, 8'hA5);
    while (!rdy && n < 20) begin @(negedge clk); rdy = h22.word_ready; n++; end
    repeat (5) begin @(posedge clk); #1; end
    send_word(0, 8'h3C);
    wait_done(0, 40);
    tick();
    vectors++;
    if (gap_cnt != 6) begin errors++; $display("FAIL stall_gap_cycles: got %0d want 6", gap_cnt); end
    vectors++;
    if (set_cnt != 24) begin errors++; $display("FAIL stall_setup_cycles: got %0d want 24", set_cnt); end
    vectors++;
    if (max_run != 16) begin errors++; $display("FAIL stall_longest_run: got %0d want 16", max_run); end
    vectors++;
    if (done_cyc - start_cyc != 31) begin
      errors++; $display("FAIL stall_done_latency: got %0d want 31", done_cyc - start_cyc);
    end
    vectors++;
    if (ch22[21:0] !== 22'h3FA53C) begin
      errors++; $display("FAIL stall_chain: got %h want 3fa53c", ch22[21:0]);
    end
  endtask

  task automatic test_ignore();
    preload22(24'h000000);
    mon_clear();
    h22.word_in = 8'h5A; h22.word_valid = 1'b1;
    start22 = 1'b1;
    tick();
    wait_done(0, 40);
    start22 = 1'b0;
    tick();
    vectors++;
    if (busy22 !== 1'b0) begin errors++; $display("FAIL ignore_back_idle: busy=%b want 0", busy22); end
    tick();
    h22.word_valid = 1'b0;
    vectors++;
    if (busy22 !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: busy=%b want 0", busy22); end
    vectors++;
    if (hs_cnt != 3) begin errors++; $display("FAIL ignore_handshakes: got %0d want 3", hs_cnt); end
    vectors++;
    if (start_cnt != 1) begin errors++; $display("FAIL ignore_loads: got %0d want 1", start_cnt); end
    vectors++;
    if (ch22[21:0] !== 22'h1A5A5A) begin
      errors++; $display("FAIL ignore_chain: got %h want 1a5a5a", ch22[21:0]);
    end
  endtask

  task automatic test_reset_midload();
    int n = 0;
    preload22(24'h000000);
    mon_clear();
    do_start(0);
    send_word(0, 8'hFF); send_word(0, 8'hA5);
    while (set_cnt < 10 && n < 50) begin tick(); n++; end
    vectors++;
    if (set_cnt < 10) begin errors++; $display("FAIL midload_shifts: got %0d want >=10", set_cnt); end
    rst_n = 1'b0;
    tick();
    check_idle_outputs("midload_reset");
    rst_n = 1'b1;
    tick();
    mon_clear();
    do_start(0);
    send_word(0, 8'hFF); send_word(0, 8'hA5); send_word(0, 8'h3C);
    wait_done(0, 40);
    tick();
    vectors++;
    if (ch22[21:0] !== 22'h3FA53C) begin
      errors++; $display("FAIL reload_chain: got %h want 3fa53c", ch22[21:0]);
    end
    vectors++;
    if (set_cnt != 24) begin errors++; $display("FAIL reload_setup_cycles: got %0d want 24", set_cnt); end
  endtask

  task automatic test_long_chain();
    logic [95:0] r;
    logic [87:0] old, exp88;
    logic [7:0]  wd[11];
    r = {$urandom(), $urandom(), $urandom()};
    old = r[87:0];
    exp88 = '0;
    for (int i = 0; i < 11; i++) begin
      wd[i] = 8'($urandom());
      exp88 = {exp88[79:0], wd[i]};
    end
    preload88(old);
    mon_clear();
    do_start(1);
    for (int i = 0; i < 11; i++) send_word(1, wd[i]);
    wait_done(1, 200);
    tick();
    vectors++;
    if (ch88 !== exp88) begin errors++; $display("FAIL long_chain: got %h want %h", ch88, exp88); end
    vectors++;
    if (rd88.size() != 11) begin errors++; $display("FAIL long_rb_count: got %0d want 11", rd88.size()); end
    for (int k = 0; k < 11; k++) begin
      vectors++;
      if (rd88[k] !== old[87-8*k -: 8]) begin
        errors++; $display("FAIL long_rb_word%0d: got %h want %h", k, rd88[k], old[87-8*k -: 8]);
      end
    end
    vectors++;
    if (done_no_rv88 != 0) begin errors++; $display("FAIL long_rb_last_with_done: got %0d want 0", done_no_rv88); end
  endtask

  initial begin
    rst_n = 1'b0; start22 = 1'b0; start88 = 1'b0;
    h22.word_in = '0; h22.word_valid = 1'b0;
    h88.word_in = '0; h88.word_valid = 1'b0;
    pre22_val = '0; pre88_val = '0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_ignore();
    test_reset_midload();
    test_long_chain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
